// File: rtl/cnn_pkg.sv
// Shared constants and types for the input stream mux.
package cnn_pkg;

    localparam int unsigned DATA_W_DEF = 16;  // Q8.8 signed samples
    localparam int unsigned N_CH_DEF   = 3;
    localparam int unsigned SEL_W_DEF  = 2;

    // Source channel indices
    localparam int unsigned CH_CAMERA = 0;
    localparam int unsigned CH_TEST   = 1;
    localparam int unsigned CH_MEM    = 2;

    // Frame tracking state on the input side
    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StStream = 1'b1
    } mux_state_e;

endpackage

// File: rtl/input_stream_mux_if.sv
// Stream, select and status signals of the input stream mux.
interface input_stream_mux_if #(
    parameter int unsigned DATA_W = cnn_pkg::DATA_W_DEF,
    parameter int unsigned N_CH   = cnn_pkg::N_CH_DEF,
    parameter int unsigned SEL_W  = cnn_pkg::SEL_W_DEF
);

    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH-1:0]        in_valid;
    logic [N_CH-1:0]        in_last;
    logic [N_CH-1:0]        in_ready;
    logic [SEL_W-1:0]       sel_req;
    logic                   sel_update;
    logic [DATA_W-1:0]      out_data;
    logic                   out_valid;
    logic                   out_last;
    logic                   out_ready;
    logic [SEL_W-1:0]       active_sel;
    logic                   busy;
    logic [15:0]            frame_cnt;

    // Mux side
    modport slave (
        input  in_data, in_valid, in_last, sel_req, sel_update, out_ready,
        output in_ready, out_data, out_valid, out_last, active_sel, busy, frame_cnt
    );

    // Environment side: sources, selector and downstream sink
    modport master (
        output in_data, in_valid, in_last, sel_req, sel_update, out_ready,
        input  in_ready, out_data, out_valid, out_last, active_sel, busy, frame_cnt
    );

endinterface

// File: rtl/stream_skid_buf.sv
// Two-entry registered stream buffer carrying data and last.
// Empty entries are held at zero so the output reads 0 whenever o_valid is low.
module stream_skid_buf #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    input  logic              i_ready
);

    logic [1:0]        r_count;
    logic [DATA_W-1:0] r_data0;
    logic [DATA_W-1:0] r_data1;
    logic              r_last0;
    logic              r_last1;

    logic [1:0]        w_count_nxt;
    logic [DATA_W-1:0] w_data0_nxt;
    logic [DATA_W-1:0] w_data1_nxt;
    logic              w_last0_nxt;
    logic              w_last1_nxt;
    logic              w_push;
    logic              w_pop;

    // Handshakes; ready comes from registered occupancy only
    always_comb begin
        o_ready = (r_count != 2'd2);
        o_valid = (r_count != 2'd0);
        o_data  = r_data0;
        o_last  = r_last0;
        w_push  = i_valid && o_ready;
        w_pop   = o_valid && i_ready;
    end

    // Entry 0 is the head; pops shift entry 1 forward and zero the vacated slot
    always_comb begin
        w_count_nxt = r_count;
        w_data0_nxt = r_data0;
        w_data1_nxt = r_data1;
        w_last0_nxt = r_last0;
        w_last1_nxt = r_last1;
        case (r_count)
            2'd0: begin
                if (w_push) begin
                    w_data0_nxt = i_data;
                    w_last0_nxt = i_last;
                    w_count_nxt = 2'd1;
                end
            end
            2'd1: begin
                if (w_push && w_pop) begin
                    w_data0_nxt = i_data;
                    w_last0_nxt = i_last;
                end else if (w_push) begin
                    w_data1_nxt = i_data;
                    w_last1_nxt = i_last;
                    w_count_nxt = 2'd2;
                end else if (w_pop) begin
                    w_data0_nxt = '0;
                    w_last0_nxt = 1'b0;
                    w_count_nxt = 2'd0;
                end
            end
            2'd2: begin
                if (w_pop) begin
                    w_data0_nxt = r_data1;
                    w_last0_nxt = r_last1;
                    w_data1_nxt = '0;
                    w_last1_nxt = 1'b0;
                    w_count_nxt = 2'd1;
                end
            end
            default: begin
                w_count_nxt = 2'd0;
                w_data0_nxt = '0;
                w_data1_nxt = '0;
                w_last0_nxt = 1'b0;
                w_last1_nxt = 1'b0;
            end
        endcase
    end

    // Buffer storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_data0 <= '0;
            r_data1 <= '0;
            r_last0 <= 1'b0;
            r_last1 <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_data0 <= w_data0_nxt;
            r_data1 <= w_data1_nxt;
            r_last0 <= w_last0_nxt;
            r_last1 <= w_last1_nxt;
        end
    end

endmodule

// File: rtl/input_stream_mux.sv
// Routes one of N_CH input streams through a 2-entry skid buffer. The source only
// changes between frames; a select request during a frame waits until it closes.
module input_stream_mux
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned N_CH   = N_CH_DEF,
    parameter int unsigned SEL_W  = SEL_W_DEF
) (
    input logic               clk,
    input logic               rst_n,
    input_stream_mux_if.slave bus_if
);

    mux_state_e        r_state;
    mux_state_e        w_state_nxt;
    logic [SEL_W-1:0]  r_active_sel;
    logic [SEL_W-1:0]  w_active_sel_nxt;
    logic              r_pend_valid;
    logic              w_pend_valid_nxt;
    logic [SEL_W-1:0]  r_pend_sel;
    logic [SEL_W-1:0]  w_pend_sel_nxt;
    logic [15:0]       r_frame_cnt;
    logic              r_ready_en;

    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_valid;
    logic              w_sel_last;
    logic              w_chan_ok;
    logic              w_buf_ready;
    logic              w_take;
    logic              w_accept;
    logic              w_open;
    logic              w_close;
    logic [DATA_W-1:0] w_out_data;
    logic              w_out_valid;
    logic              w_out_last;

    // Pick the active channel; an out-of-range select leaves everything at zero
    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_chan_ok   = 1'b0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (r_active_sel == SEL_W'(k)) begin
                w_chan_ok   = 1'b1;
                w_sel_data  = bus_if.in_data[k*DATA_W +: DATA_W];
                w_sel_valid = bus_if.in_valid[k];
                w_sel_last  = bus_if.in_last[k];
            end
        end
    end

    // Acceptance qualifiers and per-channel ready
    always_comb begin
        w_take   = r_ready_en && w_chan_ok && w_buf_ready;
        w_accept = w_sel_valid && w_take;
        w_open   = w_accept && !w_sel_last;
        w_close  = (r_state == StStream) && w_accept && w_sel_last;
        bus_if.in_ready = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            bus_if.in_ready[k] = w_take && (r_active_sel == SEL_W'(k));
        end
    end

    stream_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_accept),
        .i_data  (w_sel_data),
        .i_last  (w_sel_last),
        .o_ready (w_buf_ready),
        .o_valid (w_out_valid),
        .o_data  (w_out_data),
        .o_last  (w_out_last),
        .i_ready (bus_if.out_ready)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: a frame opens on a non-last beat and closes on a last beat
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:   if (w_open) w_state_nxt = StStream;
            StStream: if (w_close) w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    // FSM and status outputs
    always_comb begin
        bus_if.busy       = (r_state == StStream);
        bus_if.active_sel = r_active_sel;
        bus_if.frame_cnt  = r_frame_cnt;
        bus_if.out_data   = w_out_data;
        bus_if.out_valid  = w_out_valid;
        bus_if.out_last   = w_out_last;
    end

    // Select update: immediate between frames, otherwise deferred to the closing beat
    always_comb begin
        w_active_sel_nxt = r_active_sel;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_sel_nxt   = r_pend_sel;
        if (w_close) begin
            w_pend_valid_nxt = 1'b0;
            if (bus_if.sel_update) begin
                w_active_sel_nxt = bus_if.sel_req;
            end else if (r_pend_valid) begin
                w_active_sel_nxt = r_pend_sel;
            end
        end else if (bus_if.sel_update) begin
            // A request arriving with the opening beat must not split that frame
            if ((r_state == StIdle) && !w_open) begin
                w_active_sel_nxt = bus_if.sel_req;
                w_pend_valid_nxt = 1'b0;
            end else begin
                w_pend_valid_nxt = 1'b1;
                w_pend_sel_nxt   = bus_if.sel_req;
            end
        end
    end

    // Select, pending request and frame counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active_sel <= '0;
            r_pend_valid <= 1'b0;
            r_pend_sel   <= '0;
            r_frame_cnt  <= 16'd0;
        end else begin
            r_active_sel <= w_active_sel_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_sel   <= w_pend_sel_nxt;
            if (w_accept && w_sel_last) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    // Holds all in_ready low until the first clock edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

endmodule

// File: tb/tb_input_stream_mux.sv
// Scoreboard bench for input_stream_mux: the driver queues each accepted beat,
// a monitor pops and compares whenever the mux hands a beat downstream.
module tb_input_stream_mux;
    import cnn_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned NC = 3;
    localparam int unsigned SW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_chk    = 0;
    int n_pass   = 0;
    int n_popped = 0;
    int rdy_mode = 0;  // 0: out_ready high, 1: pattern 1,0,0,1, 2: out_ready low

    logic [16:0] sb_q[$];  // {last, data}

    always #5 clk = ~clk;

    input_stream_mux_if #(.DATA_W(DW), .N_CH(NC), .SEL_W(SW)) bus ();

    input_stream_mux #(
        .DATA_W (DW),
        .N_CH   (NC),
        .SEL_W  (SW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Downstream ready driver
    initial begin
        int ph;
        ph = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: bus.out_ready = 1'b1;
                1: begin
                    bus.out_ready = (ph == 0 || ph == 3);
                    ph = (ph + 1) % 4;
                end
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Output monitor
    initial begin
        logic [16:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.out_valid && bus.out_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_unexpected_beat", {15'd0, bus.out_last, bus.out_data}, 32'hdead);
                    end else begin
                        exp = sb_q.pop_front();
                        chk("out_data", bus.out_data, exp[15:0]);
                        chk("out_last", bus.out_last, exp[16]);
                        n_popped++;
                    end
                end
                if (!bus.out_valid) chk("idle_zero", {bus.out_last, bus.out_data}, 0);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is accepted
    task automatic send(input int ch, input logic [15:0] data, input logic last,
                        input logic upd, input logic [1:0] upd_sel, output int waits);
        logic done;
        done  = 1'b0;
        waits = 0;
        bus.in_valid             = '0;
        bus.in_valid[ch]         = 1'b1;
        bus.in_last              = '0;
        bus.in_last[ch]          = last;
        bus.in_data[ch*DW +: DW] = data;
        bus.sel_req              = upd_sel;
        bus.sel_update           = upd;
        while (!done && waits < 50) begin
            @(negedge clk);
            done = bus.in_ready[ch];
            if (done) sb_q.push_back({last, data});
            @(posedge clk);
            #1;
            bus.sel_update = 1'b0;
            if (!done) waits++;
        end
        bus.in_valid = '0;
        bus.in_last  = '0;
        chk("send_accepted", done, 1);
    endtask

    task automatic do_sel(input logic [1:0] s);
        bus.sel_req    = s;
        bus.sel_update = 1'b1;
        @(posedge clk);
        #1;
        bus.sel_update = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || bus.out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drained", sb_q.size(), 0);
    endtask

    initial begin
        int w;
        int tot;
        int base;
        int n;
        logic done;

        bus.in_data    = {16'h0300, 16'h0200, 16'h0100};
        bus.in_valid   = '0;
        bus.in_last    = '0;
        bus.sel_req    = '0;
        bus.sel_update = 1'b0;

        // Reset state, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_active_sel", bus.active_sel, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_frame_cnt", bus.frame_cnt, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_pre_edge", bus.in_ready, 0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_first_edge", bus.in_ready, 3'b001);

        // Single-beat frames from each channel with 1-cycle latency
        do_sel(2'(CH_CAMERA));
        chk("sel_cam", bus.active_sel, CH_CAMERA);
        send(CH_CAMERA, 16'h0100, 1'b1, 1'b0, 2'd0, w);
        chk("lat_valid_ch0", bus.out_valid, 1);
        chk("lat_data_ch0", bus.out_data, 16'h0100);
        chk("busy_single_beat", bus.busy, 0);
        do_sel(2'(CH_TEST));
        chk("sel_test", bus.active_sel, CH_TEST);
        send(CH_TEST, 16'h0200, 1'b1, 1'b0, 2'd0, w);
        chk("lat_valid_ch1", bus.out_valid, 1);
        chk("lat_data_ch1", bus.out_data, 16'h0200);
        do_sel(2'(CH_MEM));
        chk("sel_mem", bus.active_sel, CH_MEM);
        send(CH_MEM, 16'h0300, 1'b1, 1'b0, 2'd0, w);
        chk("lat_valid_ch2", bus.out_valid, 1);
        chk("lat_data_ch2", bus.out_data, 16'h0300);
        wait_drain();
        chk("frame_cnt_3", bus.frame_cnt, 3);

        // Invalid select blocks every channel
        do_sel(2'd3);
        chk("sel_invalid", bus.active_sel, 3);
        bus.in_valid = 3'b111;
        bus.in_last  = 3'b111;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("inv_in_ready", bus.in_ready, 0);
        chk("inv_out_valid", bus.out_valid, 0);
        chk("inv_out_data", bus.out_data, 0);
        chk("inv_frame_cnt", bus.frame_cnt, 3);
        bus.in_valid = '0;
        bus.in_last  = '0;

        // Select request mid-frame is deferred to the closing beat
        do_sel(2'd0);
        send(0, 16'h0A01, 1'b0, 1'b0, 2'd0, w);
        chk("busy_open", bus.busy, 1);
        send(0, 16'h0A02, 1'b0, 1'b1, 2'd1, w);
        chk("pend_held_b2", bus.active_sel, 0);
        send(0, 16'h0A03, 1'b0, 1'b0, 2'd0, w);
        chk("pend_held_b3", bus.active_sel, 0);
        chk("busy_mid", bus.busy, 1);
        send(0, 16'h0A04, 1'b1, 1'b0, 2'd0, w);
        chk("pend_applied", bus.active_sel, 1);
        chk("busy_closed", bus.busy, 0);
        send(1, 16'h0200, 1'b1, 1'b0, 2'd0, w);
        wait_drain();
        chk("frame_cnt_5", bus.frame_cnt, 5);

        // Request on the closing beat itself
        send(1, 16'h0C01, 1'b0, 1'b0, 2'd0, w);
        send(1, 16'h0C02, 1'b1, 1'b1, 2'd2, w);
        chk("sel_on_close", bus.active_sel, 2);

        // Request with the opening beat, then a newer one: the newer wins
        send(2, 16'h0D01, 1'b0, 1'b1, 2'd1, w);
        chk("open_beat_req_deferred", bus.active_sel, 2);
        chk("busy_after_open_req", bus.busy, 1);
        send(2, 16'h0D02, 1'b0, 1'b1, 2'd0, w);
        send(2, 16'h0D03, 1'b1, 1'b0, 2'd0, w);
        chk("last_req_wins", bus.active_sel, 0);
        wait_drain();
        chk("frame_cnt_7", bus.frame_cnt, 7);

        // 8-beat frame under a stalling downstream
        rdy_mode = 1;
        base = n_popped;
        for (int i = 0; i < 8; i++) begin
            send(0, 16'h0B00 + 16'(i), (i == 7), 1'b0, 2'd0, w);
        end
        wait_drain();
        chk("toggle_beat_count", n_popped - base, 8);

        // 8-beat frame at full rate
        rdy_mode = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            send(0, 16'h0B80 + 16'(i), (i == 7), 1'b0, 2'd0, w);
            tot += w;
        end
        chk("full_rate_stalls", tot, 0);
        wait_drain();
        chk("frame_cnt_9", bus.frame_cnt, 9);

        // Reset in the middle of a buffered frame
        rdy_mode = 2;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        do_sel(2'd1);
        send(1, 16'h0E01, 1'b0, 1'b0, 2'd0, w);
        send(1, 16'h0E02, 1'b0, 1'b0, 2'd0, w);
        chk("pre_rst_busy", bus.busy, 1);
        chk("pre_rst_out_valid", bus.out_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_data", bus.out_data, 0);
        chk("mid_rst_out_last", bus.out_last, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_frame_cnt", bus.frame_cnt, 0);
        chk("mid_rst_active_sel", bus.active_sel, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n    = 1'b1;
        rdy_mode = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_valid", bus.out_valid, 0);
        end
        chk("post_rst_in_ready", bus.in_ready, 3'b001);

        // Drive frame_cnt to 0xFFFF with back-to-back single-beat frames, then wrap
        bus.in_data[15:0] = 16'h0100;
        bus.in_valid      = 3'b001;
        bus.in_last       = 3'b001;
        n    = 0;
        done = 1'b0;
        while (!done && n < 70000) begin
            @(negedge clk);
            if (bus.in_ready[0]) sb_q.push_back({1'b1, 16'h0100});
            done = bus.in_ready[0] && (bus.frame_cnt == 16'hFFFE);
            n++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = '0;
        bus.in_last  = '0;
        chk("cnt_at_ffff", bus.frame_cnt, 16'hFFFF);
        @(posedge clk);
        #1;
        send(0, 16'h0F00, 1'b1, 1'b0, 2'd0, w);
        chk("cnt_wrapped", bus.frame_cnt, 16'h0000);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/input_stream_mux.md
INPUT_STREAM_MUX -- requirements
Module: input_stream_mux

Interface
REQ-001 Parameter DATA_W, default 16, sample width (Q8.8 signed at default).
REQ-002 Parameter N_CH, default 3, number of source channels (ch0 camera, ch1 test, ch2 memory); legal range 2..16.
REQ-003 Parameter SEL_W, default 2, selector width; SHALL be at least clog2(N_CH).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_data  input  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
REQ-007 in_valid  input  N_CH  per-channel beat valid.
REQ-008 in_last  input  N_CH  per-channel end-of-frame marker, qualified by in_valid.
REQ-009 in_ready  output  N_CH  per-channel ready.
REQ-010 sel_req  input  SEL_W  requested source.
REQ-011 sel_update  input  1  one-cycle strobe loading sel_req.
REQ-012 out_data  output  DATA_W  selected sample, registered.
REQ-013 out_valid / out_last  output  1 each  output beat valid / end-of-frame.
REQ-014 out_ready  input  1  downstream ready.
REQ-015 active_sel  output  SEL_W  source currently routed.
REQ-016 busy  output  1  high while a frame is in progress on the input side.
REQ-017 frame_cnt  output  16  frames completed at input side; wraps 0xFFFF->0x0000.

Function
REQ-018 Handshake: beat transfers when valid and ready are both high in the same cycle; valid SHALL NOT depend on ready.
REQ-019 Only in_ready[active_sel] may be high; all other in_ready bits 0.
REQ-020 Output path: 2-entry skid buffer; in_ready[active_sel] = buffer not full; first-beat latency 1 cycle; full throughput (1 beat/cycle) with out_ready held high.
REQ-021 Data, last, and order SHALL pass unmodified; no beat dropped or duplicated under any out_ready pattern.
REQ-022 FSM states: IDLE (no frame open), STREAM (frame open). IDLE->STREAM on accepted input beat with in_last=0; STREAM->IDLE on accepted beat with in_last=1; single-beat frame (last on first beat) stays IDLE.
REQ-023 sel_update in IDLE: active_sel takes sel_req on the next cycle.
REQ-024 sel_update in STREAM: sel_req stored as pending; applied the cycle after the last beat is accepted; multiple updates while pending: last one wins.
REQ-025 sel_update in the same cycle as the closing last beat: treated as pending; applied next cycle.
REQ-026 active_sel >= N_CH (invalid): all in_ready 0, no new beats enter; buffered beats still drain; out_data SHALL read 0 whenever out_valid is 0.
REQ-027 busy = (state == STREAM).
REQ-028 frame_cnt increments by 1 on each accepted input beat with in_last=1.

Reset
REQ-029 On rst_n low, immediately: state IDLE, skid buffer empty, out_valid 0, out_last 0, out_data 0, in_ready all 0, active_sel 0, pending cleared, busy 0, frame_cnt 0.
REQ-030 Reset mid-frame discards buffered and partial-frame data; no out_valid until new input after release.
REQ-031 First in_ready may assert on the first clk edge after rst_n deasserts.

Structure
REQ-032 Shared package cnn_pkg SHALL hold DATA_W default, channel index constants (CH_CAMERA=0, CH_TEST=1, CH_MEM=2), and the FSM state enum.
REQ-033 Skid buffer SHALL be one sub-module, stream_skid_buf, parametrised by DATA_W, carrying data+last.

Verification
REQ-034 ch0=0x0100, ch1=0x0200, ch2=0x0300 single-beat frames, sel 0,1,2 in IDLE -> out_data 0x0100, 0x0200, 0x0300 in order, 1-cycle latency each, frame_cnt=3.
REQ-035 Select 3 (invalid) with all channels valid -> in_ready=000, out_valid=0, out_data=0x0000.
REQ-036 4-beat frame on ch0, sel_update to 1 at beat 2 -> all 4 ch0 beats out, active_sel becomes 1 the cycle after beat 4 accepted; next beat 0x0200.
REQ-037 Streaming 8 beats with out_ready toggling 1,0,0,1 -> all 8 beats out in order, no loss or duplication; continuous 1/cycle when out_ready held high.
REQ-038 rst_n pulsed low at beat 2 of a 4-beat frame -> outputs zero immediately, busy=0, frame_cnt=0, active_sel=0.
REQ-039 1 cycle after frame_cnt reaches 0xFFFF, one more frame ends -> frame_cnt=0x0000.
